rbcp_reg_responder: RTL and testbench

RBCP slave-side responder: the register end of the SiTCP RBCP UDP slow-control channel. It decodes the RBCP_ACT/ADDR/WD/WE/RE strobes issued by the SiTCP core, maintains a bank of byte-wide R/W control registers plus a read-only status window, and returns RBCP_ACK/RBCP_RD. It sits in the 200 MHz SiTCP system clock domain beside the SiTCP wrapper, in place of a tie-off on the RBCP port.

---
 rtl/rbcp_reg_responder.sv | 154 +++++++++++++++
 tb/tb_rbcp_reg_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rbcp_reg_responder.sv
// RBCP slave responder: byte-wide R/W control bank plus read-only status window.
// Optional macro RBCP_REG_WSTB_EN adds per-register write strobes (REG_WSTB).
module rbcp_reg_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_REGS  = 16,
  parameter logic [7:0]  STAT_OFS  = 8'h80,
  parameter logic [7:0]  REG_INIT  = 8'h00
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  RBCP_ACT,
  input  logic [31:0]           RBCP_ADDR,
  input  logic [7:0]            RBCP_WD,
  input  logic                  RBCP_WE,
  input  logic                  RBCP_RE,
  output logic                  RBCP_ACK,
  output logic [7:0]            RBCP_RD,
  output logic [NUM_REGS*8-1:0] REG_OUT,
`ifdef RBCP_REG_WSTB_EN
  output logic [NUM_REGS-1:0]   REG_WSTB,
`endif
  input  logic [63:0]           STAT_IN
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_e;

  localparam logic [8:0] NREG9   = 9'(NUM_REGS);
  localparam logic [8:0] STAT_LO = {1'b0, STAT_OFS};
  localparam logic [8:0] STAT_HI = STAT_LO + 9'd8;

  state_e     state_q, state_d;
  logic [7:0] off_q, off_d;
  logic [7:0] wd_q, wd_d;
  logic       wr_q, wr_d;
  logic [7:0] rd_q;
  logic [7:0] regs_q [NUM_REGS];

  logic [8:0] in_off;
  logic       hit;
  logic       start;
  logic       ctrl_q;
  logic       commit;
  logic [7:0] rd_mux;

  assign in_off = {1'b0, RBCP_ADDR[7:0]};
  assign hit = (RBCP_ADDR[31:8] == BASE_ADDR[31:8]) &&
               ((in_off < NREG9) ||
                ((in_off >= STAT_LO) && (in_off < STAT_HI)));
  assign start = RBCP_ACT && (RBCP_WE ^ RBCP_RE) && hit;
  assign ctrl_q = ({1'b0, off_q} < NREG9);
  // Aborted writes still commit; only the ACK is dropped.
  assign commit = (state_q == ACCESS) && wr_q && ctrl_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    wd_d    = wd_q;
    wr_d    = wr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCESS;
          off_d   = RBCP_ADDR[7:0];
          wd_d    = RBCP_WD;
          wr_d    = RBCP_WE;
        end
      end
      ACCESS:  state_d = RBCP_ACT ? ACK : IDLE;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      off_q <= 8'h00;
      wd_q  <= 8'h00;
      wr_q  <= 1'b0;
    end else begin
      off_q <= off_d;
      wd_q  <= wd_d;
      wr_q  <= wr_d;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (off_q == 8'(n)) rd_mux = regs_q[n];
    end
    for (int k = 0; k < 8; k++) begin
      if (off_q == STAT_OFS + 8'(k)) rd_mux = STAT_IN[8*k +: 8];
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= REG_INIT;
    end else if (commit) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        if (off_q == 8'(n)) regs_q[n] <= wd_q;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_q <= 8'h00;
    end else if ((state_q == ACCESS) && !wr_q && RBCP_ACT) begin
      rd_q <= rd_mux;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign REG_OUT[8*g +: 8] = regs_q[g];
  end

  assign RBCP_ACK = (state_q == ACK);
  assign RBCP_RD  = rd_q;

`ifdef RBCP_REG_WSTB_EN
  logic [NUM_REGS-1:0] wstb_q, wstb_d;

  always_comb begin
    wstb_d = '0;
    for (int n = 0; n < NUM_REGS; n++) begin
      wstb_d[n] = commit && RBCP_ACT && (off_q == 8'(n));
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wstb_q <= '0;
    end else begin
      wstb_q <= wstb_d;
    end
  end

  assign REG_WSTB = wstb_q;
`endif

endmodule

// File: tb/tb_rbcp_reg_responder.sv
// Bench for rbcp_reg_responder: directed cases plus randomized traffic vs a
// byte-array model. Define RBCP_REG_WSTB_EN to also check REG_WSTB.
module tb_rbcp_reg_responder;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic         RBCP_ACT;
  logic [31:0]  RBCP_ADDR;
  logic [7:0]   RBCP_WD;
  logic         RBCP_WE;
  logic         RBCP_RE;
  logic         RBCP_ACK;
  logic [7:0]   RBCP_RD;
  logic [127:0] REG_OUT;
  logic [63:0]  STAT_IN;
`ifdef RBCP_REG_WSTB_EN
  logic [15:0]  REG_WSTB;
`endif

  rbcp_reg_responder dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .RBCP_ACT  (RBCP_ACT),
    .RBCP_ADDR (RBCP_ADDR),
    .RBCP_WD   (RBCP_WD),
    .RBCP_WE   (RBCP_WE),
    .RBCP_RE   (RBCP_RE),
    .RBCP_ACK  (RBCP_ACK),
    .RBCP_RD   (RBCP_RD),
    .REG_OUT   (REG_OUT),
`ifdef RBCP_REG_WSTB_EN
    .REG_WSTB  (REG_WSTB),
`endif
    .STAT_IN   (STAT_IN)
  );

  always #5 CLK = ~CLK;

  int         nvec = 0;
  int         nerr = 0;
  logic [7:0] mregs [16];
  logic [7:0] mrd;

  function automatic logic [127:0] model_out();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = mregs[i];
    return v;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int o;
    o = int'(a[7:0]);
    return (a[31:8] == 24'h0) && ((o < 16) || (o >= 128 && o < 136));
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic count_acks(input string tag, input int want);
    int acks;
    acks = 0;
    repeat (20) begin
      @(negedge CLK);
      if (RBCP_ACK === 1'b1) acks++;
    end
    check(tag, 128'(acks), 128'(want));
  endtask

  task automatic xact(input bit we, input logic [31:0] a, input logic [7:0] d);
    int  o;
    bit  hit;
    logic [15:0] exp_stb;
    o = int'(a[7:0]);
    hit = model_hit(a);
    exp_stb = 16'h0;
    @(negedge CLK);
    RBCP_ACT = 1'b1; RBCP_WE = we; RBCP_RE = !we;
    RBCP_ADDR = a; RBCP_WD = d;
    @(posedge CLK);
    #1 RBCP_WE = 1'b0; RBCP_RE = 1'b0;
    if (hit) begin
      if (we && o < 16) begin
        mregs[o] = d;
        exp_stb[o] = 1'b1;
      end else if (!we) begin
        mrd = (o < 16) ? mregs[o] : STAT_IN[8*(o-128) +: 8];
      end
      @(negedge CLK);
      check("ack_t1", 128'(RBCP_ACK), 128'(0));
      @(negedge CLK);
      check("ack_t2", 128'(RBCP_ACK), 128'(1));
      check("rd", 128'(RBCP_RD), 128'(mrd));
      check("regout", REG_OUT, model_out());
`ifdef RBCP_REG_WSTB_EN
      check("wstb", 128'(REG_WSTB), 128'(exp_stb));
`endif
      @(negedge CLK);
      check("ack_t3", 128'(RBCP_ACK), 128'(0));
`ifdef RBCP_REG_WSTB_EN
      check("wstb_off", 128'(REG_WSTB), 128'(0));
`endif
    end else begin
      count_acks("miss_ack", 0);
      check("miss_rd", 128'(RBCP_RD), 128'(mrd));
      check("miss_regout", REG_OUT, model_out());
    end
    RBCP_ACT = 1'b0;
  endtask

  initial begin
    RSTn = 1'b0; RBCP_ACT = 1'b0; RBCP_WE = 1'b0; RBCP_RE = 1'b0;
    RBCP_ADDR = 32'h0; RBCP_WD = 8'h0; STAT_IN = 64'h0;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mrd = 8'h00;
    #12;
    check("rst_ack", 128'(RBCP_ACK), 128'(0));
    check("rst_rd", 128'(RBCP_RD), 128'(0));
    check("rst_regout", REG_OUT, 128'(0));
    @(negedge CLK) RSTn = 1'b1;

    xact(1'b0, 32'h0000_0003, 8'h00);
    xact(1'b1, 32'h0000_0005, 8'hA5);
    check("reg5", 128'(REG_OUT[47:40]), 128'(8'hA5));
    xact(1'b0, 32'h0000_0005, 8'h00);
    check("rd_a5", 128'(RBCP_RD), 128'(8'hA5));

    STAT_IN = 64'h0000_0000_003C_0000;
    xact(1'b0, 32'h0000_0082, 8'h00);
    xact(1'b1, 32'h0000_0082, 8'hFF);
    xact(1'b0, 32'h0000_0082, 8'h00);
    check("stat_rd", 128'(RBCP_RD), 128'(8'h3C));

    xact(1'b1, 32'h0000_0010, 8'h99);
    xact(1'b0, 32'h0000_0010, 8'h00);
    xact(1'b1, 32'h0000_0088, 8'h99);
    xact(1'b0, 32'h0000_0088, 8'h00);
    xact(1'b1, 32'h0000_0105, 8'h99);
    xact(1'b0, 32'h0000_0105, 8'h00);
    xact(1'b0, 32'h0000_007F, 8'h00);

    // WE and RE together
    @(negedge CLK);
    RBCP_ACT = 1'b1; RBCP_WE = 1'b1; RBCP_RE = 1'b1;
    RBCP_ADDR = 32'h2; RBCP_WD = 8'h77;
    @(posedge CLK);
    #1 RBCP_WE = 1'b0; RBCP_RE = 1'b0;
    count_acks("we_re_ack", 0);
    check("we_re_regout", REG_OUT, model_out());
    RBCP_ACT = 1'b0;

    // second WE right behind an accepted one
    @(negedge CLK);
    RBCP_ACT = 1'b1; RBCP_WE = 1'b1; RBCP_ADDR = 32'h2; RBCP_WD = 8'h11;
    @(posedge CLK);
    #1 RBCP_ADDR = 32'h3; RBCP_WD = 8'h22;
    @(posedge CLK);
    #1 RBCP_WE = 1'b0;
    mregs[2] = 8'h11;
    count_acks("dbl_we_ack", 1);
    check("dbl_we_regout", REG_OUT, model_out());
    RBCP_ACT = 1'b0;

    // ACT dropped in ACCESS
    @(negedge CLK);
    RBCP_ACT = 1'b1; RBCP_WE = 1'b1; RBCP_ADDR = 32'h1; RBCP_WD = 8'h5A;
    @(posedge CLK);
    #1 RBCP_WE = 1'b0; RBCP_ACT = 1'b0;
    mregs[1] = 8'h5A;
    count_acks("abort_ack", 0);
    check("abort_reg1", 128'(REG_OUT[15:8]), 128'(8'h5A));
    check("abort_regout", REG_OUT, model_out());

    // reset during ACCESS of a read
    @(negedge CLK);
    RBCP_ACT = 1'b1; RBCP_RE = 1'b1; RBCP_ADDR = 32'h5;
    @(posedge CLK);
    #1 RBCP_RE = 1'b0; RSTn = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    mrd = 8'h00;
    check("mid_rst_ack", 128'(RBCP_ACK), 128'(0));
    check("mid_rst_rd", 128'(RBCP_RD), 128'(0));
    check("mid_rst_regout", REG_OUT, model_out());
    @(negedge CLK);
    check("mid_rst_ack2", 128'(RBCP_ACK), 128'(0));
    RSTn = 1'b1; RBCP_ACT = 1'b0;
    @(negedge CLK);
    check("post_rst_ack", 128'(RBCP_ACK), 128'(0));
    xact(1'b0, 32'h0000_0005, 8'h00);

    xact(1'b1, 32'h0000_0007, 8'hC3);
    xact(1'b1, 32'h0000_0007, 8'hC3);

    for (int it = 0; it < 60; it++) begin
      logic [31:0] a;
      int          kind;
      STAT_IN = {$urandom, $urandom};
      kind = $urandom_range(0, 9);
      if (kind < 7) a = 32'($urandom_range(0, 15));
      else if (kind < 9) a = 32'h80 + 32'($urandom_range(0, 7));
      else a = 32'h10 + 32'($urandom_range(0, 15));
      xact(1'($urandom_range(0, 1)), a, 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
